// File: rtl/uart_defs.sv
// Shared UART defaults: data width, RX FIFO depth and thresholds, plus the
// pointer-width helper used by the receive buffer.
package uart_defs;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_RX_DEPTH   = 16;
   localparam int DEF_AF_THRESH  = DEF_RX_DEPTH - 2;
   localparam int DEF_AE_THRESH  = 1;

   // Index width for a power-of-two depth; pointers carry one extra wrap bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// RX FIFO storage: DATA_WIDTH x DEPTH, one synchronous write port and one
// asynchronous read port so the head word is available with zero latency.
module rx_fifo_mem
   import uart_defs::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_RX_DEPTH,
   localparam int AW        = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]         i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rx_fifo_param.sv
// Parametrised first-word-fall-through UART receive FIFO with occupancy level,
// almost-full/almost-empty flags, sticky overrun and synchronous flush.
module rx_fifo_param
   import uart_defs::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_RX_DEPTH,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = DEF_AE_THRESH,
   localparam int AW        = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [AW:0]           level,
   output logic                  overrun,
   input  logic                  ovr_clr
);

   localparam logic [AW:0] C_ONE   = (AW+1)'(1);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_AF    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] C_AE    = (AW+1)'(AE_THRESH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic [AW:0] r_level;
   logic        r_overrun;

   logic        w_rd_acc;
   logic        w_wr_acc;
   logic        w_drop;

   assign full         = (r_level == C_DEPTH);
   assign empty        = (r_level == '0);
   assign almost_full  = (r_level >= C_AF);
   assign almost_empty = (r_level <= C_AE);
   assign level        = r_level;
   assign overrun      = r_overrun;

   // Flush masks both requests, so nothing is stored or popped in that cycle.
   assign w_rd_acc = rd_en && !empty && !flush;
   assign w_wr_acc = wr_en && !flush && (!full || w_rd_acc);
   assign w_drop   = wr_en && !flush && full && !w_rd_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + C_ONE;
            2'b01:   r_level <= r_level - C_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // A drop in the same cycle as a software clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (ovr_clr) begin
         r_overrun <= 1'b0;
      end
   end

   rx_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr[AW-1:0]),
      .i_wdata (wr_data),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (rd_data)
   );

endmodule

// File: tb/tb_rx_fifo_param.sv
// Directed bench for rx_fifo_param (DEPTH=16, DATA_WIDTH=8): reset, fill/drain,
// wrap-around, simultaneous access at the boundaries, overrun and flush.
module tb_rx_fifo_param;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       almost_full;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       almost_empty;
   logic [4:0] level;
   logic       overrun;
   logic       ovr_clr;

   int n_cmp;
   int n_err;

   rx_fifo_param #(
      .DATA_WIDTH (8),
      .DEPTH      (16),
      .AF_THRESH  (14),
      .AE_THRESH  (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .almost_full  (almost_full),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty        (empty),
      .almost_empty (almost_empty),
      .level        (level),
      .overrun      (overrun),
      .ovr_clr      (ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Drive one cycle of requests, let the edge happen, then idle the inputs.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
      wr_en = w; wr_data = d; rd_en = r; flush = f; ovr_clr = c;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
      rd_en = 1'b0; ovr_clr = 1'b0;

      // Reset state and hold after release
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_ae", 32'(almost_empty), 32'd1);
      chk("rst_af", 32'(almost_full), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rel_empty", 32'(empty), 32'd1);
      chk("rel_level", 32'(level), 32'd0);

      // Asynchronous reset mid-transfer
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
      chk("pre_arst_level", 32'(level), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         chk($sformatf("fill_level_%0d", i), 32'(level), 32'(i + 1));
         chk($sformatf("fill_af_%0d", i), 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_empty", 32'(empty), 32'd0);

      // Drain in order
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain_data_%0d", i), 32'(rd_data), 32'(i));
         chk($sformatf("drain_ae_%0d", i), 32'(almost_empty), (16 - i <= 1) ? 32'd1 : 32'd0);
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_ae", 32'(almost_empty), 32'd1);

      // Push 10, pop 10
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      chk("w10_level", 32'(level), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("p10_data_%0d", i), 32'(rd_data), 32'(8'h30 + i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      chk("p10_empty", 32'(empty), 32'd1);

      // Streaming 0xA0..0xB3 across the pointer wrap
      cyc(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 20; i++) begin
         chk($sformatf("wrap_data_%0d", i - 1), 32'(rd_data), 32'(8'hA0 + i - 1));
         cyc(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b0);
         chk($sformatf("wrap_level_%0d", i), 32'(level), 32'd1);
      end
      chk("wrap_last", 32'(rd_data), 32'h0000_00B3);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("wrap_empty", 32'(empty), 32'd1);

      // Write+read while full
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      chk("sf_full", 32'(full), 32'd1);
      chk("sf_head", 32'(rd_data), 32'h0000_0060);
      cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      chk("sf_level", 32'(level), 32'd16);
      chk("sf_head2", 32'(rd_data), 32'h0000_0061);

      // Overrun set, clear, and set-wins-over-clear
      cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_level", 32'(level), 32'd16);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovr_clr", 32'(overrun), 32'd0);
      cyc(1'b1, 8'h78, 1'b0, 1'b0, 1'b1);
      chk("ovr_setwins", 32'(overrun), 32'd1);

      // Drain: 0x61..0x6F then 0x55; the dropped words never appear
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("sf_drain_%0d", i), 32'(rd_data), 32'(8'h61 + i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      chk("sf_last55", 32'(rd_data), 32'h0000_0055);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("sf_empty", 32'(empty), 32'd1);

      // Write+read while empty: write only
      cyc(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
      chk("se_level", 32'(level), 32'd1);
      chk("se_data", 32'(rd_data), 32'h0000_0044);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("se_empty", 32'(empty), 32'd1);

      // Flush at level 5 with a concurrent write
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      chk("fl_pre_level", 32'(level), 32'd5);
      cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      chk("fl_level", 32'(level), 32'd0);
      chk("fl_empty", 32'(empty), 32'd1);
      chk("fl_ovr", 32'(overrun), 32'd1);
      cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
      chk("fl_wlevel", 32'(level), 32'd1);
      chk("fl_data", 32'(rd_data), 32'h0000_0012);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("fl_empty2", 32'(empty), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rx_fifo_param.md
Name: rx_fifo_param

Overview:
Parametrised successor to the UART receive buffer. It is a first-word-fall-through FIFO with configurable width and depth, and sits between the UART RX deserialiser (write side) and the AXI-Lite register read path (read side). Compared with the fixed 4-entry buffer it adds:
- occupancy level output
- almost-full / almost-empty thresholds
- a sticky overrun flag with software clear
- synchronous flush
- write-while-full when a read occurs in the same cycle

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- DEPTH, 16: number of entries; power of two, minimum 2.
- AF_THRESH, DEPTH-2: almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when level <= AE_THRESH.
- Local AW = $clog2(DEPTH): pointer index width. Pointers are AW+1 bits (wrap bit).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request from RX deserialiser
- wr_data  in  DATA_WIDTH  word to store
- full  out  1  level == DEPTH
- almost_full  out  1  level >= AF_THRESH
- rd_en  in  1  pop request (AXI read of the RX data register)
- rd_data  out  DATA_WIDTH  head word, combinational (FWFT)
- empty  out  1  level == 0
- almost_empty  out  1  level <= AE_THRESH
- level  out  AW+1  current occupancy, 0..DEPTH
- overrun  out  1  sticky: a write was dropped
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, level=0, overrun=0. Outputs: empty=1, full=0, almost_empty=1, almost_full=0. Storage is not reset.
- Derived flags: full, empty, almost_full and almost_empty are combinational from level. level is a registered counter.
- Read accepted (rd_acc) = rd_en && !empty.
- Write accepted (wr_acc) = wr_en && (!full || rd_acc). A write while full is accepted only if a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr[AW-1:0]] <= wr_data; wr_ptr increments.
- On rd_acc: rd_ptr increments.
- Level update:
  - level +1 on wr_acc only.
  - level -1 on rd_acc only.
  - unchanged on both or neither.
- Pointers wrap naturally modulo 2*DEPTH.
- rd_data = mem[rd_ptr[AW-1:0]], valid in the same cycle that empty=0 (zero-latency read). When empty, rd_data is don't-care.
- Write-to-read latency: a word written at edge N is visible on rd_data and empty drops after edge N.
- Overrun: wr_en && full && !rd_acc sets overrun at the next edge and the word is discarded.
- ovr_clr clears overrun. If a new drop event and ovr_clr occur in the same cycle, set wins.
- Flush (synchronous):
  - Pointers and level go to 0 at the next edge.
  - Flush overrides wr_en and rd_en in that cycle; no write is stored.
  - overrun is not affected by flush.
- rd_en while empty is ignored: no pointer change, no error flag.
- Reset asserted mid-transfer: all state is cleared immediately, regardless of the clock.

Decomposition:
- Shared package/header (uart_defs) holds:
  - default DATA_WIDTH (8)
  - default RX FIFO DEPTH (16)
  - default thresholds
  - the $clog2-based width helper
- Sub-module: a storage array rx_fifo_mem is natural, with a 1-write/1-async-read port, DATA_WIDTH x DEPTH. All control logic stays in the top level.

Test Plan:
- Reset and idle: assert rst_n=0 mid-cycle -> empty=1, full=0, level=0, overrun=0 immediately. Release -> values hold.
- Fill and drain (DEPTH=16): write 0x00..0x0F ->
  - full=1, level=16, almost_full rises at level 14
  - read 16x -> data 0x00..0x0F in order, empty=1
  - almost_empty=1 at level<=1
- Wrap-around: push 10, pop 10, then push/pop 20 words (0xA0..0xB3) -> order preserved across the pointer wrap, level never exceeds 10.
- Simultaneous at boundaries:
  - when full, wr_en+rd_en with 0x55 -> level stays 16 and 0x55 emerges last.
  - when empty, wr_en+rd_en -> write only, level=1.
- Overrun:
  - when full, wr_en with 0x77 and no read -> overrun=1 next cycle, level=16, 0x77 never read.
  - ovr_clr -> overrun=0.
  - ovr_clr together with a new drop -> overrun stays 1.
- Flush: at level 5, flush together with wr_en (0x99) -> level=0, empty=1, overrun unchanged. A subsequent write of 0x12 reads back as 0x12.
